// File: rtl/seq_scan_pkg.sv
// +----------------------------------------------------------------------+
// | seq_scan_pkg: state encoding and default geometry for the scan ctrl   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package seq_scan_pkg;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_LOAD  = 2'b01;
  localparam logic [1:0] S_SHIFT = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_LOAD  = S_LOAD,
    ST_SHIFT = S_SHIFT,
    ST_DONE  = S_DONE
  } state_t;

  localparam int         DEF_WORD_W  = 8;
  localparam int         DEF_PAT_W   = 4;
  // Wide enough for the largest pattern; instances slice the low PAT_W bits.
  localparam logic [7:0] DEF_PATTERN = 8'b0000_1010;

endpackage

`default_nettype wire

// File: rtl/seq_pat_det.sv
// +----------------------------------------------------------------------+
// | seq_pat_det: overlapping serial pattern detector, registered match    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module seq_pat_det #(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic bit_valid,
  input  logic bit_in,
  output logic match,
  output logic hit
);

  localparam logic [3:0] c_FILL_MAX = 4'(PAT_W - 1);

  logic [PAT_W-2:0] r_hist;
  logic [3:0]       r_fill;
  logic [PAT_W-1:0] w_win;

  assign w_win = {r_hist, bit_in};
  // Combinational hit lets the owner update its counter on the same edge as match.
  assign hit   = bit_valid && (r_fill >= c_FILL_MAX) && (w_win == PATTERN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist <= '0;
      r_fill <= '0;
      match  <= 1'b0;
    end else if (clr) begin
      r_hist <= '0;
      r_fill <= '0;
      match  <= 1'b0;
    end else begin
      match <= hit;
      if (bit_valid) begin
        r_hist <= w_win[PAT_W-2:0];
        if (r_fill < c_FILL_MAX) begin
          r_fill <= r_fill + 4'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_scan_ctrl.sv
// +----------------------------------------------------------------------+
// | seq_scan_ctrl: word-to-serial scan scheduler with match counting      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int               WORD_W  = DEF_WORD_W,
  parameter int               PAT_W   = DEF_PAT_W,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN[PAT_W-1:0]
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              busy,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic              overflow,
  output logic              done
);

  localparam int               BC_W      = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BC_W-1:0]  c_BC_LAST = BC_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  state_t            r_state;
  state_t            w_next;
  logic [WORD_W-1:0] r_shift;
  logic [BC_W-1:0]   r_bcnt;
  logic              r_last;
  logic              w_clr;
  logic              w_bit_valid;
  logic              w_load_hs;
  logic              w_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    w_clr       = 1'b0;
    w_bit_valid = 1'b0;
    w_load_hs   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_clr  = 1'b1;
          w_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        in_ready  = 1'b1;
        busy      = 1'b1;
        w_load_hs = in_valid;
        if (in_valid) w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy        = 1'b1;
        w_bit_valid = 1'b1;
        if (r_bcnt == '0) w_next = r_last ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift <= '0;
      r_bcnt  <= '0;
      r_last  <= 1'b0;
    end else if (w_load_hs) begin
      r_shift <= in_data;
      r_last  <= in_last;
      r_bcnt  <= c_BC_LAST;
    end else if (w_bit_valid) begin
      r_shift <= {r_shift[WORD_W-2:0], 1'b0};
      r_bcnt  <= r_bcnt - 1'b1;
    end
  end

  seq_pat_det #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_det (
    .clk       (clk),
    .reset     (reset),
    .clr       (w_clr),
    .bit_valid (w_bit_valid),
    .bit_in    (r_shift[WORD_W-1]),
    .match     (match_pulse),
    .hit       (w_hit)
  );

  // Counter saturates at all-ones; overflow latches on the edge it gets there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_count <= '0;
      overflow    <= 1'b0;
    end else if (w_clr) begin
      match_count <= '0;
      overflow    <= 1'b0;
    end else if (w_hit && (match_count != c_CNT_MAX)) begin
      match_count <= match_count + 1'b1;
      if (match_count == (c_CNT_MAX - 1'b1)) overflow <= 1'b1;
    end
  end

endmodule

`default_nettype wire
